// File: rtl/pm_frame_tx.sv
// rtl/pm_frame_tx.sv - serial command frame transmitter (start, 3 mode bits, 8 arg bits, optional parity, stop)
// Define PM_TX_PARITY_EN to insert an even-parity bit over the 11 mode+arg bits before the stop bit.
module pm_frame_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_mode,
    input  logic [7:0] in_arg,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MODE,
        S_ARG,
`ifdef PM_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [10:0] shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        in_ready_q, in_ready_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic        bit_end;
    logic        load_bit;
`ifdef PM_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        load_bit     = 1'b0;
`ifdef PM_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        bit_end = (cnt_q == 8'd0);
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? RELOAD : cnt_q - 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (in_mode == 3'b111) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = RELOAD;
                        bit_d   = 3'd0;
                        shift_d = {in_arg, in_mode};
`ifdef PM_TX_PARITY_EN
                        parity_d = ^{in_arg, in_mode};
`endif
                    end
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_MODE;
                    load_bit = 1'b1;
                end
            end
            S_MODE: begin
                if (bit_end) begin
                    load_bit = 1'b1;
                    if (bit_q == 3'd2) begin
                        state_d = S_ARG;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ARG: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef PM_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        load_bit = 1'b1;
                        bit_d    = bit_q + 3'd1;
                    end
                end
            end
`ifdef PM_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d      = S_IDLE;
                    cnt_d        = 8'd0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shift register always presents the next data bit at bit 0.
        if (load_bit) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[10:1]};
        end
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            bit_q        <= 3'd0;
            shift_q      <= 11'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef PM_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef PM_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule
